// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, scan states and hex segment table for 7-segment drivers
//
// Contents:
//   seg_t        7-bit segment vector, bit0 = a ... bit6 = g, active-high (1 = lit)
//   scan_state_t scan FSM states
//   SEG_TABLE    segment patterns for hex digits 0..F
//   hex2seg      nibble -> seg_t lookup

package seg7_pkg;

  typedef logic [6:0] seg_t;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } scan_state_t;

  localparam seg_t SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t hex2seg(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// rtl/seg7_scan_mux_if.sv - value/display bundle between hex producers, scan mux and board pins
//
// Signals:
//   en_i      scan enable (0 = display dark)
//   digits_i  NUM_DIGITS packed hex nibbles, digit 0 in bits [3:0]
//   dp_i      decimal point per digit, 1 = lit
//   seg_o     segments a..g (bit0..bit6), polarity set by the driver
//   dp_o      decimal point pin
//   an_o      digit enables, one-hot when a digit is shown
//   frame_o   one-cycle pulse at the start of each frame
// Modports: master = value producer / observer, slave = scan mux.

interface seg7_scan_mux_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic                    en_i;
  logic [4*NUM_DIGITS-1:0] digits_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  seg_t                    seg_o;
  logic                    dp_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic                    frame_o;

  modport master (
    output en_i, digits_i, dp_i,
    input  seg_o, dp_o, an_o, frame_o
  );

  modport slave (
    input  en_i, digits_i, dp_i,
    output seg_o, dp_o, an_o, frame_o
  );

endinterface

// File: rtl/seg7_hex_dec.sv
// rtl/seg7_hex_dec.sv - combinational hex nibble to 7-segment decoder
//
// Ports:
//   nibble  in   4  hex value 0..F
//   seg     out  7  active-high segments, bit0 = a ... bit6 = g

module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan_mux.sv
// rtl/seg7_scan_mux.sv - time-multiplexed multi-digit 7-segment scan driver
//
// Each digit is lit for DWELL-BLANK_CYCLES clocks and then all anodes are off
// for BLANK_CYCLES clocks, DWELL = CLK_FREQ_HZ/(FRAME_HZ*NUM_DIGITS).
// Digit values are captured into shadow registers at the start of every frame
// so a frame never mixes old and new values.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous active-high reset
//   bus   slave side of seg7_scan_mux_if (en_i, digits_i, dp_i in;
//         seg_o, dp_o, an_o, frame_o out, all registered)
//
// Build option: SEG7_LEADING_ZERO_BLANK_EN - when defined, a zero digit with
// all higher digits zero and its own dp off shows no segments (digit 0 never).

module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int FRAME_HZ     = 250,
  parameter int BLANK_CYCLES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_mux_if.slave  bus
);

  localparam int   DWELL    = CLK_FREQ_HZ / (FRAME_HZ * NUM_DIGITS);
  localparam int   SHOW_LEN = DWELL - BLANK_CYCLES;
  localparam int   CW       = $clog2(DWELL + 1);
  localparam int   IW       = $clog2(NUM_DIGITS);
  localparam logic POL      = (ACTIVE_LOW != 0);

  generate
    if (DWELL <= BLANK_CYCLES || BLANK_CYCLES < 1 || NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_cfg
      $error("seg7_scan_mux: dwell must exceed BLANK_CYCLES (>=1) and NUM_DIGITS must be 2..8");
    end
  endgenerate

  scan_state_t             state, state_d;
  logic [IW-1:0]           idx, idx_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic                    capture;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic [NUM_DIGITS-1:0]   an_d, an_q;
  seg_t                    seg_d, seg_q, dec_seg;
  logic                    dp_d, dp_q, frame_q;
  logic [3:0]              nib;
  logic                    digit_blank;

  assign nib = shadow_digits[{idx, 2'b00} +: 4];

  seg7_hex_dec u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] lz_mask;
  logic                  zero_run;

  // Walk down from the top digit; zero_run stays set while every digit so far is 0.
  always_comb begin
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (shadow_digits[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run && !shadow_dp[k];
    end
  end

  assign digit_blank = lz_mask[idx];
`else
  assign digit_blank = 1'b0;
`endif

  // Next state plus the active-high output image of the current state;
  // registering that image gives the one-cycle output lag.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    capture = 1'b0;
    an_d    = '0;
    seg_d   = '0;
    dp_d    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.en_i) begin
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
          capture = 1'b1;
        end
      end
      SHOW: begin
        an_d  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
        seg_d = digit_blank ? '0 : dec_seg;
        dp_d  = shadow_dp[idx];
        if (cnt == CW'(SHOW_LEN - 1)) begin
          state_d = BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      BLANK: begin
        if (cnt == CW'(BLANK_CYCLES - 1)) begin
          state_d = SHOW;
          cnt_d   = '0;
          if (idx == IW'(NUM_DIGITS - 1)) begin
            idx_d   = '0;
            capture = 1'b1;
          end else begin
            idx_d = idx + IW'(1);
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!bus.en_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      cnt           <= '0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      an_q          <= {NUM_DIGITS{POL}};
      seg_q         <= {7{POL}};
      dp_q          <= POL;
      frame_q       <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cnt     <= cnt_d;
      if (capture) begin
        shadow_digits <= bus.digits_i;
        shadow_dp     <= bus.dp_i;
      end
      an_q    <= an_d ^ {NUM_DIGITS{POL}};
      seg_q   <= seg_d ^ {7{POL}};
      dp_q    <= dp_d ^ POL;
      frame_q <= capture;
    end
  end

  assign bus.an_o    = an_q;
  assign bus.seg_o   = seg_q;
  assign bus.dp_o    = dp_q;
  assign bus.frame_o = frame_q;

endmodule
